// File: rtl/pwm_capture_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : pwm_capture_if                                                  |
// | Brief     : Control, PWM input and measurement results for pwm_capture.     |
// |             slave = capture block, master = controller/consumer side.       |
// | Revision  : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_level;
  logic [6:0]       duty_pct;
  logic             duty_valid;

  modport master (
    output en, pwm_in,
    input  period_out, high_out, meas_valid, timeout, stuck_level, duty_pct, duty_valid
  );

  modport slave (
    input  en, pwm_in,
    output period_out, high_out, meas_valid, timeout, stuck_level, duty_pct, duty_valid
  );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pwm_capture                                                      |
// | Brief    : PWM decoder. Measures period and high time of an asynchronous    |
// |            PWM input in clk cycles, flags stuck lines with a timeout.       |
// |            Optional duty-cycle divider enabled by macro PWM_DUTY_PCT_EN.    |
// |            CNT_W must match the CNT_W of the connected pwm_capture_if.      |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;
  logic                   rise;
  logic                   fall;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_tmp;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             load_hi;
  logic             load_meas;
  logic             hit_timeout;
  logic             meas_valid_q;
  logic             timeout_q;
  logic             stuck_q;

  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~prev;
  assign fall    = ~s & prev;
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;

  // Synchronise the raw input and keep a one-cycle delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.pwm_in};
      prev <= s;
    end
  end

  // State and cycle counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: arm on a rise, capture high time on fall, close a period on the next rise
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = rise ? CNT_ONE : cnt_inc;
    load_hi     = 1'b0;
    load_meas   = 1'b0;
    hit_timeout = 1'b0;
    if (!bus.en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = rise ? CNT_ONE : '0;
          if (rise) state_nxt = ARM;
        end
        default: begin
          // An edge in the saturation cycle still counts as activity, so no timeout then
          if (!rise && !fall && (cnt == CNT_MAX)) begin
            hit_timeout = 1'b1;
            state_nxt   = IDLE;
            cnt_nxt     = '0;
          end else if ((state == ARM || state == HIGH) && fall) begin
            state_nxt = LOW;
            load_hi   = 1'b1;
          end else if ((state == LOW) && rise) begin
            state_nxt = HIGH;
            load_meas = 1'b1;
          end
        end
      endcase
    end
  end

  // Result registers: outputs only change on a completed period or a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_tmp       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      meas_valid_q <= load_meas;
      timeout_q    <= hit_timeout;
      if (load_hi) hi_tmp <= cnt;
      if (load_meas) begin
        period_q <= cnt;
        high_q   <= hi_tmp;
      end
      if (hit_timeout) stuck_q <= s;
    end
  end

  assign bus.period_out  = period_q;
  assign bus.high_out    = high_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.stuck_level = stuck_q;

`ifdef PWM_DUTY_PCT_EN
  // Dividend high*100 needs CNT_W+7 bits; one quotient bit per cycle
  localparam int             DW      = CNT_W + 7;
  localparam int             DCW     = $clog2(DW + 1);
  localparam logic [DW-1:0]  HUNDRED = DW'(100);
  localparam logic [DCW-1:0] DSTEPS  = DCW'(DW);
  localparam logic [DCW-1:0] DONE_1  = DCW'(1);

  logic [DW-1:0]    dq;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dvs;
  logic [DCW-1:0]   dcnt;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] rem_sub;
  logic             qbit;
  logic [DW-1:0]    q_fin;
  logic [6:0]       duty_q;
  logic             duty_valid_q;

  // One restoring-division step; remainder always stays below the divisor
  always_comb begin
    rem_sh  = {rem, dq[DW-1]};
    qbit    = (rem_sh >= {1'b0, dvs});
    rem_sub = rem_sh[CNT_W-1:0] - dvs;
    q_fin   = {dq[DW-2:0], qbit};
  end

  // Divider sequencer: every new measurement restarts it, so stale results never surface
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq           <= '0;
      rem          <= '0;
      dvs          <= '0;
      dcnt         <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      duty_valid_q <= 1'b0;
      if (meas_valid_q) begin
        dq   <= DW'(high_q) * HUNDRED;
        rem  <= '0;
        dvs  <= period_q;
        dcnt <= DSTEPS;
      end else if (dcnt != '0) begin
        rem  <= qbit ? rem_sub : rem_sh[CNT_W-1:0];
        dq   <= q_fin;
        dcnt <= dcnt - DONE_1;
        if (dcnt == DONE_1) begin
          duty_valid_q <= 1'b1;
          duty_q       <= (q_fin > HUNDRED) ? 7'd100 : q_fin[6:0];
        end
      end
    end
  end

  assign bus.duty_pct   = duty_q;
  assign bus.duty_valid = duty_valid_q;
`else
  assign bus.duty_pct   = 7'd0;
  assign bus.duty_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_pwm_capture                                                   |
// | Brief    : Directed self-checking bench for pwm_capture (CNT_W=8).          |
// |            Duty checks follow macro PWM_DUTY_PCT_EN.                        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_pwm_capture;
  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  // Raw edge -> sampled by SYNC_STAGES flops -> rise cycle -> registered output
  localparam int MV_LAT      = SYNC_STAGES + 1;
  // Raw rise to timeout pulse: rise cycle loads cnt=1, timeout at cnt=2^CNT_W-1
  localparam int TO_LAT      = SYNC_STAGES + (1 << CNT_W);

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.CNT_W(CNT_W)) bus_if ();

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int     p;
    int     h;
    longint c;
  } meas_t;

  meas_t  exp_q[$];
  bit     armed = 1'b0;
  int     prev_p = 0;
  int     prev_h = 0;
  bit     to_pend = 1'b0;
  longint to_cyc = 0;
  bit     to_lvl = 1'b0;
  int     last_p = 0;
  int     last_h = 0;
  bit     duty_pend = 1'b0;
  longint duty_due = 0;
  int     duty_exp = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_period"}, bus_if.period_out, 0);
    check_eq({tag, "_high"}, bus_if.high_out, 0);
    check_eq({tag, "_mv"}, bus_if.meas_valid, 0);
    check_eq({tag, "_to"}, bus_if.timeout, 0);
    check_eq({tag, "_stuck"}, bus_if.stuck_level, 0);
    check_eq({tag, "_duty"}, bus_if.duty_pct, 0);
    check_eq({tag, "_dv"}, bus_if.duty_valid, 0);
  endtask

  // Output monitor: every pulse must match a pending expectation
  initial forever begin
    meas_t e;
    @(negedge clk);
    if (bus_if.duty_valid === 1'b1) begin
`ifdef PWM_DUTY_PCT_EN
      if (duty_pend) begin
        check_eq("duty_cycle", cyc, duty_due);
        check_eq("duty_pct", bus_if.duty_pct, duty_exp);
        duty_pend = 1'b0;
      end else begin
        check_eq("duty_valid_unexpected", 1, 0);
      end
`else
      check_eq("duty_valid_off", 1, 0);
`endif
    end
    if (bus_if.meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("meas_valid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("period_out", bus_if.period_out, e.p);
        check_eq("high_out", bus_if.high_out, e.h);
        check_eq("meas_cycle", cyc, e.c);
        last_p = e.p;
        last_h = e.h;
`ifdef PWM_DUTY_PCT_EN
        duty_pend = 1'b1;
        duty_due  = cyc + CNT_W + 8;
        duty_exp  = (e.h * 100 / e.p > 100) ? 100 : e.h * 100 / e.p;
`endif
      end
`ifndef PWM_DUTY_PCT_EN
      check_eq("duty_pct_off", bus_if.duty_pct, 0);
`endif
    end
    if (bus_if.timeout === 1'b1) begin
      if (to_pend) begin
        check_eq("timeout_cycle", cyc, to_cyc);
        check_eq("stuck_level", bus_if.stuck_level, to_lvl);
        check_eq("to_period_hold", bus_if.period_out, last_p);
        check_eq("to_high_hold", bus_if.high_out, last_h);
        to_pend = 1'b0;
      end else begin
        check_eq("timeout_unexpected", 1, 0);
      end
    end
  end

  task automatic hold(input bit lvl, input int n);
    bus_if.pwm_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A raw rise closes the previous period if the capture was armed
  task automatic mark_rise();
    if (armed) exp_q.push_back('{prev_p, prev_h, cyc + MV_LAT});
  endtask

  task automatic do_period(input int h, input int p);
    mark_rise();
    armed  = 1'b1;
    prev_p = p;
    prev_h = h;
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic start_stream();
    bus_if.en = 1'b1;
    armed     = 1'b0;
    hold(1'b0, 5);
  endtask

  task automatic close_stream();
    mark_rise();
    armed = 1'b0;
    hold(1'b1, 5);
    bus_if.en = 1'b0;
    hold(1'b0, 25);
    check_eq("queue_drained", exp_q.size(), 0);
`ifdef PWM_DUTY_PCT_EN
    check_eq("duty_drained", duty_pend, 0);
`endif
  endtask

  initial begin
    rst           = 1'b1;
    bus_if.en     = 1'b0;
    bus_if.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    hold(1'b0, 2);

    // Steady 30/100 stream: first valid at second rise, then every 100 cycles
    start_stream();
    repeat (5) do_period(30, 100);
    close_stream();

    // Stream switch 30/100 -> 25/50: no mixed sample
    start_stream();
    repeat (3) do_period(30, 100);
    repeat (3) do_period(25, 50);
    close_stream();

    // Minimum waveform 1/2
    start_stream();
    repeat (8) do_period(1, 2);
    close_stream();

    // en dropped mid-HIGH: interrupted period dropped, outputs hold
    start_stream();
    repeat (2) do_period(30, 100);
    mark_rise();
    hold(1'b1, 10);
    bus_if.en = 1'b0;
    armed     = 1'b0;
    hold(1'b1, 10);
    bus_if.en = 1'b1;
    check_eq("en_hold_period", bus_if.period_out, 100);
    check_eq("en_hold_high", bus_if.high_out, 30);
    hold(1'b1, 10);
    hold(1'b0, 70);
    repeat (2) do_period(30, 100);
    close_stream();

    // Timeout stuck high, then stuck low
    start_stream();
    to_cyc  = cyc + TO_LAT;
    to_lvl  = 1'b1;
    to_pend = 1'b1;
    hold(1'b1, 270);
    check_eq("timeout_high_seen", to_pend, 0);
    hold(1'b0, 5);
    to_cyc  = cyc + TO_LAT;
    to_lvl  = 1'b0;
    to_pend = 1'b1;
    hold(1'b1, 5);
    hold(1'b0, 270);
    check_eq("timeout_low_seen", to_pend, 0);
    check_eq("timeout_queue", exp_q.size(), 0);

    // Asynchronous reset mid-cycle during a measurement
    start_stream();
    do_period(30, 100);
    mark_rise();
    hold(1'b1, 10);
    #3;
    rst           = 1'b1;
    bus_if.pwm_in = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    exp_q.delete();
    armed     = 1'b0;
    duty_pend = 1'b0;
    last_p    = 0;
    last_h    = 0;
    @(posedge clk);
    #1;
    hold(1'b0, 5);
    rst = 1'b0;
    start_stream();
    do_period(30, 100);
    close_stream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
